// File: rtl/gts_pkg.sv
// -----------------------------------------------------------------------------
// gts_pkg
// Shared definitions for the gate truth-table sequencer:
//   - FSM state encoding (IDLE, SETTLE, SAMPLE, DONE)
//   - gate input vector width
//   - truth-table constants for common two-input gates, indexed by {a,b}
//     (bit 0 is the expected output for a=0, b=0)
//   - counter width helper
// -----------------------------------------------------------------------------
package gts_pkg;

    localparam int GTS_VEC_W = 2;

    typedef enum logic [1:0] {
        GTS_IDLE   = 2'd0,
        GTS_SETTLE = 2'd1,
        GTS_SAMPLE = 2'd2,
        GTS_DONE   = 2'd3
    } gts_state_e;

    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;

    // Width needed to hold values 0..n-1, never less than one bit.
    function automatic int gts_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gts_settle_timer.sv
// -----------------------------------------------------------------------------
// gts_settle_timer
// Loadable down-counter that times the settle interval of one vector.
// Loading sets the count to SETTLE_CYCLES-1; each decrement cycle moves it
// toward zero, so zero_o rises after SETTLE_CYCLES-1 decrements and the
// owning FSM leaves SETTLE on the SETTLE_CYCLES-th cycle.
//
// Ports:
//   clk     in   clock
//   rst     in   asynchronous active-high reset
//   load_i  in   load SETTLE_CYCLES-1 (wins over dec_i)
//   dec_i   in   decrement while non-zero
//   zero_o  out  count is zero
// -----------------------------------------------------------------------------
module gts_settle_timer
    import gts_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic dec_i,
    output logic zero_o
);

    localparam int CNT_W = gts_cnt_w(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] LOAD_VAL =
        (SETTLE_CYCLES > 0) ? CNT_W'(SETTLE_CYCLES - 1) : '0;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/gate_truth_sequencer.sv
// -----------------------------------------------------------------------------
// gate_truth_sequencer
// Drives a two-input gate through its four input vectors {a,b} = 00,01,10,11
// for PASSES sweeps, waits SETTLE_CYCLES after applying each vector, samples
// the gate output and compares it against the truth table TT. Reports a
// saturating mismatch count, a pass flag and a one-cycle done pulse.
//
// Optional feature macro: GTS_FAIL_CAPTURE_EN adds fail_vld/fail_vec, which
// record the vector of the first mismatch in a run.
//
// Ports:
//   clk          in   clock
//   rst          in   asynchronous active-high reset
//   start        in   run request, sampled in IDLE only
//   busy         out  high in SETTLE and SAMPLE (registered)
//   done         out  one-cycle pulse while in DONE (registered)
//   dut_a        out  gate input a (registered)
//   dut_b        out  gate input b (registered)
//   dut_y        in   gate output
//   err_cnt      out  saturating mismatch count of the last run
//   pass         out  last run completed with no mismatch
//   dbg_state_o  out  current FSM state (gts_state_e encoding)
//   fail_vld     out  (GTS_FAIL_CAPTURE_EN) a mismatch was captured this run
//   fail_vec     out  (GTS_FAIL_CAPTURE_EN) {a,b} of the first mismatch
//
// Handshake: start is a level request that is only looked at in IDLE; a
// run, once accepted, cannot be queued behind or restarted by start. done is
// a single-cycle pulse and err_cnt/pass are valid while it is high and hold
// until the next accepted start.
// -----------------------------------------------------------------------------
module gate_truth_sequencer
    import gts_pkg::*;
#(
    parameter int         SETTLE_CYCLES = 2,
    parameter int         PASSES        = 1,
    parameter logic [3:0] TT            = TT_NAND,
    parameter int         ERR_W         = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 dut_a,
    output logic                 dut_b,
    input  logic                 dut_y,
    output logic [ERR_W-1:0]     err_cnt,
    output logic                 pass,
    output logic [1:0]           dbg_state_o
`ifdef GTS_FAIL_CAPTURE_EN
    ,
    output logic                 fail_vld,
    output logic [GTS_VEC_W-1:0] fail_vec
`endif
);

    localparam int PASS_W = gts_cnt_w(PASSES);
    localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(PASSES - 1);
    localparam bit HAS_SETTLE = (SETTLE_CYCLES > 0);
    // With no settle time a freshly applied vector is sampled on the next cycle.
    localparam gts_state_e APPLY_ST = HAS_SETTLE ? GTS_SETTLE : GTS_SAMPLE;

    gts_state_e            state_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  dut_a_q;
    logic                  dut_b_q;
    logic [ERR_W-1:0]      err_cnt_q;
    logic [ERR_W-1:0]      err_cnt_d;
    logic                  pass_q;
    logic [GTS_VEC_W-1:0]  vec_idx_q;
    logic [GTS_VEC_W-1:0]  vec_idx_d;
    logic [PASS_W-1:0]     pass_idx_q;

    logic                  exp_y;
    logic                  mismatch;
    logic                  last_vec;
    logic                  tmr_load;
    logic                  tmr_dec;
    logic                  tmr_zero;

`ifdef GTS_FAIL_CAPTURE_EN
    logic                  fail_vld_q;
    logic [GTS_VEC_W-1:0]  fail_vec_q;
`endif

    // ------------------------------------------------------------------
    // Checker: case inequality so an x or z gate output counts as a miss.
    // ------------------------------------------------------------------
    assign exp_y    = TT[{dut_a_q, dut_b_q}];
    assign mismatch = (dut_y !== exp_y);
    assign last_vec = (vec_idx_q == 2'd3) && (pass_idx_q == LAST_PASS);
    assign vec_idx_d = vec_idx_q + 2'd1;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if ((state_q == GTS_SAMPLE) && mismatch && !(&err_cnt_q)) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Settle timer: reloaded whenever a vector is applied.
    // ------------------------------------------------------------------
    always_comb begin
        tmr_load = 1'b0;
        if (HAS_SETTLE) begin
            if ((state_q == GTS_IDLE) && start) begin
                tmr_load = 1'b1;
            end
            if ((state_q == GTS_SAMPLE) && !last_vec) begin
                tmr_load = 1'b1;
            end
        end
    end

    assign tmr_dec = (state_q == GTS_SETTLE);

    gts_settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load_i (tmr_load),
        .dec_i  (tmr_dec),
        .zero_o (tmr_zero)
    );

    // ------------------------------------------------------------------
    // Sequencer FSM with registered outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= GTS_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dut_a_q    <= 1'b0;
            dut_b_q    <= 1'b0;
            err_cnt_q  <= '0;
            pass_q     <= 1'b0;
            vec_idx_q  <= '0;
            pass_idx_q <= '0;
`ifdef GTS_FAIL_CAPTURE_EN
            fail_vld_q <= 1'b0;
            fail_vec_q <= '0;
`endif
        end else begin
            case (state_q)
                GTS_IDLE: begin
                    if (start) begin
                        state_q    <= APPLY_ST;
                        busy_q     <= 1'b1;
                        err_cnt_q  <= '0;
                        pass_q     <= 1'b0;
                        dut_a_q    <= 1'b0;
                        dut_b_q    <= 1'b0;
                        vec_idx_q  <= '0;
                        pass_idx_q <= '0;
`ifdef GTS_FAIL_CAPTURE_EN
                        fail_vld_q <= 1'b0;
                        fail_vec_q <= '0;
`endif
                    end
                end

                GTS_SETTLE: begin
                    if (tmr_zero) begin
                        state_q <= GTS_SAMPLE;
                    end
                end

                GTS_SAMPLE: begin
                    err_cnt_q <= err_cnt_d;
`ifdef GTS_FAIL_CAPTURE_EN
                    // First mismatch of the run wins; later ones never overwrite it.
                    if (mismatch && !fail_vld_q) begin
                        fail_vld_q <= 1'b1;
                        fail_vec_q <= {dut_a_q, dut_b_q};
                    end
`endif
                    if (last_vec) begin
                        state_q    <= GTS_DONE;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        pass_q     <= (err_cnt_d == '0);
                        dut_a_q    <= 1'b0;
                        dut_b_q    <= 1'b0;
                        vec_idx_q  <= '0;
                        pass_idx_q <= '0;
                    end else begin
                        state_q   <= APPLY_ST;
                        vec_idx_q <= vec_idx_d;
                        dut_a_q   <= vec_idx_d[1];
                        dut_b_q   <= vec_idx_d[0];
                        if (vec_idx_q == 2'd3) begin
                            pass_idx_q <= pass_idx_q + PASS_W'(1);
                        end
                    end
                end

                GTS_DONE: begin
                    state_q <= GTS_IDLE;
                    done_q  <= 1'b0;
                end

                default: begin
                    state_q <= GTS_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign dut_a       = dut_a_q;
    assign dut_b       = dut_b_q;
    assign err_cnt     = err_cnt_q;
    assign pass        = pass_q;
    assign dbg_state_o = state_q;

`ifdef GTS_FAIL_CAPTURE_EN
    assign fail_vld = fail_vld_q;
    assign fail_vec = fail_vec_q;
`endif

endmodule

// File: tb/tb_gate_truth_sequencer.sv
// -----------------------------------------------------------------------------
// tb_gate_truth_sequencer
// Three sequencer instances with different parameter sets share one clock and
// reset:
//   id 0: SETTLE=2, PASSES=1, ERR_W=4, NAND
//   id 1: SETTLE=2, PASSES=2, ERR_W=2, NAND
//   id 2: SETTLE=0, PASSES=1, ERR_W=4, XOR
// Each instance sees a gate model whose response per input vector is a table
// (correct, inverted, x or z). Expected results come from counting table
// entries that disagree with the truth table and from the edge-level schedule.
// -----------------------------------------------------------------------------
module tb_gate_truth_sequencer;
    import gts_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    int         s_tab [3] = '{2, 2, 0};
    int         p_tab [3] = '{1, 2, 1};
    int         w_tab [3] = '{4, 2, 4};
    logic [3:0] tt_tab[3] = '{4'b0111, 4'b0111, 4'b0110};

    logic       start_v[3];
    logic       y_v[3];
    logic       resp[3][4];
    logic       busy_v[3];
    logic       done_v[3];
    logic       a_v[3];
    logic       b_v[3];
    logic       pass_v[3];
    logic [1:0] dbg_v[3];
    logic [3:0] err0, err2;
    logic [1:0] err1;
    logic [3:0] err_v[3];
`ifdef GTS_FAIL_CAPTURE_EN
    logic       fvld_v[3];
    logic [1:0] fvec_v[3];
`endif

    assign err_v[0] = err0;
    assign err_v[1] = {2'b00, err1};
    assign err_v[2] = err2;

    assign y_v[0] = resp[0][{a_v[0], b_v[0]}];
    assign y_v[1] = resp[1][{a_v[1], b_v[1]}];
    assign y_v[2] = resp[2][{a_v[2], b_v[2]}];

    gate_truth_sequencer #(.SETTLE_CYCLES(2), .PASSES(1), .TT(4'b0111), .ERR_W(4)) u0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .dut_a(a_v[0]), .dut_b(b_v[0]), .dut_y(y_v[0]), .err_cnt(err0), .pass(pass_v[0]),
        .dbg_state_o(dbg_v[0])
`ifdef GTS_FAIL_CAPTURE_EN
        , .fail_vld(fvld_v[0]), .fail_vec(fvec_v[0])
`endif
    );

    gate_truth_sequencer #(.SETTLE_CYCLES(2), .PASSES(2), .TT(4'b0111), .ERR_W(2)) u1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .dut_a(a_v[1]), .dut_b(b_v[1]), .dut_y(y_v[1]), .err_cnt(err1), .pass(pass_v[1]),
        .dbg_state_o(dbg_v[1])
`ifdef GTS_FAIL_CAPTURE_EN
        , .fail_vld(fvld_v[1]), .fail_vec(fvec_v[1])
`endif
    );

    gate_truth_sequencer #(.SETTLE_CYCLES(0), .PASSES(1), .TT(4'b0110), .ERR_W(4)) u2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .busy(busy_v[2]), .done(done_v[2]),
        .dut_a(a_v[2]), .dut_b(b_v[2]), .dut_y(y_v[2]), .err_cnt(err2), .pass(pass_v[2]),
        .dbg_state_o(dbg_v[2])
`ifdef GTS_FAIL_CAPTURE_EN
        , .fail_vld(fvld_v[2]), .fail_vec(fvec_v[2])
`endif
    );

    // mode: 0 ideal, 1 stuck at 1, 2 stuck at 0, 3 always x, 4 random per vector
    task automatic set_resp(input int id, input int mode);
        logic [3:0] tt;
        tt = tt_tab[id];
        for (int v = 0; v < 4; v++) begin
            case (mode)
                0: resp[id][v] = tt[v];
                1: resp[id][v] = 1'b1;
                2: resp[id][v] = 1'b0;
                3: resp[id][v] = 1'bx;
                default: begin
                    case ($urandom_range(0, 3))
                        0: resp[id][v] = tt[v];
                        1: resp[id][v] = ~tt[v];
                        2: resp[id][v] = 1'bx;
                        default: resp[id][v] = 1'bz;
                    endcase
                end
            endcase
        end
    endtask

    // One complete run on instance id, checked edge by edge against the
    // schedule. With hold=1 start stays high: it must be ignored until IDLE
    // is re-entered, then start a second run two edges after the done edge.
    task automatic run_check(input int id, input bit hold, input string nm);
        int s, p, w, mism, first, total, exp_err, e_last, seen;
        logic [3:0] tt;
        logic [3:0] exp_err4;
        logic [1:0] exp_vec;
        logic       exp_busy;
        s = s_tab[id];
        p = p_tab[id];
        w = w_tab[id];
        tt = tt_tab[id];
        mism = 0;
        first = -1;
        for (int v = 0; v < 4; v++) begin
            if (resp[id][v] !== tt[v]) begin
                mism++;
                if (first < 0) first = v;
            end
        end
        total = mism * p;
        exp_err = (total > (1 << w) - 1) ? (1 << w) - 1 : total;
        exp_err4 = 4'(exp_err);
        e_last = 4 * p * (s + 1);

        @(negedge clk);
        start_v[id] = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (busy_v[id] !== 1'b1 || {a_v[id], b_v[id]} !== 2'b00 || done_v[id] !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s edge0: busy=%b ab=%b%b done=%b, want busy=1 ab=00 done=0",
                     nm, busy_v[id], a_v[id], b_v[id], done_v[id]);
        end
        tests_run++;
        if (err_v[id] !== 4'd0 || pass_v[id] !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s clear_on_start: err=%0d pass=%b, want 0 0", nm, err_v[id], pass_v[id]);
        end
        if (!hold) start_v[id] = 1'b0;

        for (int e = 1; e <= e_last + 3; e++) begin
            @(posedge clk);
            #1;
            exp_busy = (e < e_last) || (hold && e >= e_last + 2);
            tests_run++;
            if (busy_v[id] !== exp_busy) begin
                tests_failed++;
                $display("FAIL %s busy@%0d: got %b want %b", nm, e, busy_v[id], exp_busy);
            end
            if ((e % (s + 1) == 0) && (e < e_last)) begin
                exp_vec = 2'((e / (s + 1)) % 4);
                tests_run++;
                if ({a_v[id], b_v[id]} !== exp_vec) begin
                    tests_failed++;
                    $display("FAIL %s vector@%0d: got %b%b want %b", nm, e, a_v[id], b_v[id], exp_vec);
                end
            end
            if (e == e_last) begin
                tests_run++;
                if (done_v[id] !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL %s done@%0d: got %b want 1", nm, e, done_v[id]);
                end
                tests_run++;
                if (err_v[id] !== exp_err4) begin
                    tests_failed++;
                    $display("FAIL %s err_cnt: got %0d want %0d", nm, err_v[id], exp_err4);
                end
                tests_run++;
                if (pass_v[id] !== (total == 0)) begin
                    tests_failed++;
                    $display("FAIL %s pass: got %b want %b", nm, pass_v[id], (total == 0));
                end
                tests_run++;
                if ({a_v[id], b_v[id]} !== 2'b00) begin
                    tests_failed++;
                    $display("FAIL %s done_ab: got %b%b want 00", nm, a_v[id], b_v[id]);
                end
`ifdef GTS_FAIL_CAPTURE_EN
                tests_run++;
                if (fvld_v[id] !== (total != 0) || (total != 0 && fvec_v[id] !== 2'(first))) begin
                    tests_failed++;
                    $display("FAIL %s fail_capture: vld=%b vec=%b want vld=%b vec=%0d",
                             nm, fvld_v[id], fvec_v[id], (total != 0), first);
                end
`endif
            end else begin
                tests_run++;
                if (done_v[id] !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL %s done@%0d: got %b want 0", nm, e, done_v[id]);
                end
            end
            if (e == e_last + 1 && !hold) begin
                tests_run++;
                if (err_v[id] !== exp_err4 || pass_v[id] !== (total == 0) || dbg_v[id] !== GTS_IDLE) begin
                    tests_failed++;
                    $display("FAIL %s hold_after_done: err=%0d pass=%b st=%0d want %0d %b idle",
                             nm, err_v[id], pass_v[id], dbg_v[id], exp_err4, (total == 0));
                end
            end
        end
        start_v[id] = 1'b0;

        if (hold) begin
            seen = 0;
            for (int c = 0; c < 200 && seen == 0; c++) begin
                @(posedge clk);
                #1;
                if (done_v[id] === 1'b1) seen = 1;
            end
            tests_run++;
            if (seen == 0) begin
                tests_failed++;
                $display("FAIL %s restart_done: no done within 200 cycles, want one", nm);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
        end
        for (int i = 0; i < 3; i++) set_resp(i, 0);
        #12;
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (busy_v[i] !== 1'b0 || done_v[i] !== 1'b0 || a_v[i] !== 1'b0 || b_v[i] !== 1'b0 ||
                err_v[i] !== 4'd0 || pass_v[i] !== 1'b0 || dbg_v[i] !== GTS_IDLE) begin
                tests_failed++;
                $display("FAIL reset_values u%0d: busy=%b done=%b a=%b b=%b err=%0d pass=%b st=%0d, want all 0",
                         i, busy_v[i], done_v[i], a_v[i], b_v[i], err_v[i], pass_v[i], dbg_v[i]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_ideal();
        for (int i = 0; i < 3; i++) begin
            set_resp(i, 0);
            run_check(i, 1'b0, $sformatf("ideal_u%0d", i));
        end
    endtask

    task automatic test_faults();
        set_resp(0, 1);
        run_check(0, 1'b0, "stuck1_u0");
        set_resp(0, 3);
        run_check(0, 1'b0, "x_u0");
        set_resp(1, 2);
        run_check(1, 1'b0, "saturate_u1");
        set_resp(2, 3);
        run_check(2, 1'b0, "x_u2");
    endtask

    task automatic test_abort_reset();
        int seen;
        set_resp(0, 3);
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        tests_run++;
        if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0 || a_v[0] !== 1'b0 || b_v[0] !== 1'b0 ||
            err_v[0] !== 4'd0 || pass_v[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_reset_values: busy=%b done=%b a=%b b=%b err=%0d pass=%b, want all 0",
                     busy_v[0], done_v[0], a_v[0], b_v[0], err_v[0], pass_v[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 16; c++) begin
            @(posedge clk);
            #1;
            if (done_v[0] !== 1'b0 || busy_v[0] !== 1'b0) seen = 1;
        end
        tests_run++;
        if (seen != 0) begin
            tests_failed++;
            $display("FAIL abort_no_done: activity after reset seen=%0d want 0", seen);
        end
        set_resp(0, 0);
        run_check(0, 1'b0, "after_abort_u0");
    endtask

    task automatic test_back_to_back();
        set_resp(2, 4);
        run_check(2, 1'b1, "held_start_u2");
        set_resp(0, 0);
        run_check(0, 1'b1, "held_start_u0");
    endtask

    task automatic test_random();
        int id;
        for (int n = 0; n < 9; n++) begin
            id = $urandom_range(0, 2);
            set_resp(id, 4);
            run_check(id, 1'b0, $sformatf("random%0d_u%0d", n, id));
        end
    endtask

    initial begin
        test_reset();
        test_ideal();
        test_faults();
        test_abort_reset();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/gate_truth_sequencer.md
# gate_truth_sequencer

Sequencing controller that exercises a two-input switch-level gate, such as the CMOS NAND, through its full truth table. On a start request it drives the gate inputs through the four input vectors, waits a programmable settle time per vector and samples the gate output. It checks each sample against a parameterised truth table and reports a saturating mismatch count, a pass flag and a done pulse. It sits between a test/control host and one gate instance, and replaces hand-written stimulus sequences in gate-level benches.

## Interface
- `SETTLE_CYCLES`, default 2: cycles between applying a vector and sampling it; 0 is legal.
- `PASSES`, default 1: number of full 4-vector sweeps per run; must be ≥1.
- `TT`, default 4'b0111: expected output indexed by `{a,b}` (bit0 = `a0 b0`). The default is NAND.
- `ERR_W`, default 4: width of the mismatch counter.
- `clk  in  1`: clock.
- `rst  in  1`: asynchronous, active-high reset.
- `start  in  1`: run request, sampled in IDLE only.
- `busy  out  1`: high in SETTLE and SAMPLE.
- `done  out  1`: one-cycle pulse, high in DONE.
- `dut_a  out  1`: gate input 1, registered.
- `dut_b  out  1`: gate input 2, registered.
- `dut_y  in  1`: gate output.
- `err_cnt  out  ERR_W`: saturating mismatch count.
- `pass  out  1`: high when the run completed with `err_cnt == 0`.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE. Reset state is IDLE.
- Reset values: `busy=0`, `done=0`, `dut_a=0`, `dut_b=0`, `err_cnt=0`, `pass=0`, vector index 0, pass index 0.
- **IDLE, `start=1`:**
  - go to SETTLE;
  - clear `err_cnt` and `pass`;
  - drive vector 0 (`dut_a=0`, `dut_b=0`);
  - load the settle counter.
- **IDLE, `start=0`:** hold all outputs.
- **SETTLE:** stay for `SETTLE_CYCLES` cycles, then go to SAMPLE. With `SETTLE_CYCLES=0` the machine goes directly from IDLE/SAMPLE to SAMPLE.
- **SAMPLE (1 cycle):**
  - compare `dut_y` with `TT[{dut_a,dut_b}]` using case inequality;
  - `dut_y` of x or z is a mismatch;
  - on a mismatch, `err_cnt` increments and saturates at all-ones.
- **Leaving SAMPLE:**
  - if this was vector 3 of the last pass, go to DONE;
  - otherwise advance the vector (index wraps 3→0 and increments the pass index), drive the new vector and go to SETTLE.
- **Vector order:** `{a,b}` = 00, 01, 10, 11.
- **DONE (1 cycle):**
  - `done=1`;
  - `pass` is set to `(err_cnt_final == 0)`;
  - `dut_a` and `dut_b` return to 0;
  - go to IDLE.
- `err_cnt` and `pass` hold until the next accepted start.
- `start` while busy or in DONE is ignored. It is neither queued nor restarts the run.
- Reset asserted mid-run:
  - all state returns to reset values asynchronously;
  - no `done` pulse;
  - partial counts are discarded.

## Timing
- The edge that accepts `start` is edge 0.
- Vector k of the whole run (k = 0 … 4·PASSES−1):
  - is applied at edge k·(S+1);
  - is sampled at edge k·(S+1)+S+1, where S = `SETTLE_CYCLES`.
- `done` is high for the cycle after edge 4·PASSES·(S+1). With the defaults this is edge 12.
- `err_cnt` and `pass` are valid when `done` is high.
- Back-to-back runs: the earliest next `start` is sampled the cycle after DONE, in IDLE.

## Configuration
- `GTS_FAIL_CAPTURE_EN` defined:
  - adds `fail_vld out 1` and `fail_vec out 2` (`{a,b}` of the first mismatch in the run), both reset to 0;
  - both are cleared on accepted start;
  - `fail_vld` sets on the first mismatch and the captured value is never overwritten in that run.
- `GTS_FAIL_CAPTURE_EN` undefined: these ports and their registers are absent. All other behaviour is identical.

## Structure
- Shared package `gts_pkg` holds:
  - the state encoding (IDLE, SETTLE, SAMPLE, DONE);
  - vector width 2;
  - truth-table constants `TT_NAND=4'b0111`, `TT_NOR=4'b0001`, `TT_AND=4'b1000`, `TT_OR=4'b1110`, `TT_XOR=4'b0110`.
- One sub-module, `gts_settle_timer`: a loadable down-counter with a `zero` flag, sized from `SETTLE_CYCLES`. The FSM, vector/pass indices and checker live in the top.

## Test plan
- Ideal NAND model, defaults, `start` for one cycle → vectors 00/01/10/11 on edges 0/3/6/9, `done` after edge 12, `err_cnt=0`, `pass=1`.
- `dut_y` stuck at 1 → `err_cnt=1`, `pass=0`; with the macro, `fail_vld=1` and `fail_vec=2'b11`.
- `dut_y` tied to x → `err_cnt=4`, `pass=0`.
- `ERR_W=2`, `PASSES=2`, `dut_y` stuck at 0 → 6 mismatches, `err_cnt` saturates at 3.
- Reset asserted at edge 5, then a new start → no `done` pulse from the aborted run, outputs at reset values, and the new run completes normally.
- `SETTLE_CYCLES=0`, `start` held high throughout → one sample per cycle, `done` after edge 4, and no restart until IDLE is re-entered.
